systolic_seq_ctrl: RTL
======================

Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N array of floating-point MAC PEs. Each PE's accumulator updates once every BEAT cycles.
- On a start pulse, the block:
  - clears the PE accumulators,
  - steps through K operand beats, driving per-row A and per-column B buffer read addresses with systolic wavefront skew,
  - waits out the multiply/add pipeline drain,
  - signals done.
- Sits between the host/DMA command interface and the PE-array wrapper, which handles neighbour forwarding.

Parameters:
- N, 4, array dimension (rows = columns).
- KW, 8, width of k_len; max K = 2^KW-1.
- BEAT, 6, cycles per MAC beat; matches the PE accumulation period.
- CLR_CYC, 2, cycles pe_clr_n is held low before feeding.
- DRAIN, 12, cycles waited after the last beat before results are valid.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse, sampled only in IDLE
- k_len  in  KW  dot-product length, captured with start
- busy  out  1  high in CLEAR, FEED and DRAIN
- done  out  1  one-cycle pulse; PE outputs valid from this cycle until the next start
- pe_clr_n  out  1  active-low accumulator clear to the PE array
- beat_strobe  out  1  high on the first cycle of each FEED beat
- beat_idx  out  KW+1  current beat number t
- skew_mask  out  N  bit i = row i and column i edge operands are live this beat
- a_addr  out  N*KW  packed; field i = A read index for row i
- b_addr  out  N*KW  packed; field j = B read index for column j

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE.
  - busy=0, done=0, pe_clr_n=0, beat_strobe=0, beat_idx=0, skew_mask=0, a_addr=0, b_addr=0.
  - pe_clr_n is registered and returns to 1 on the first clock in IDLE after reset release.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches k_len into K.
  - If K != 0, go to CLEAR.
  - If K == 0, go to CLEAR and then straight to DONE, skipping FEED and DRAIN. The result is all-zero accumulators.
- CLEAR:
  - pe_clr_n=0 for exactly CLR_CYC cycles, then goes to FEED.
  - Beat t=0 starts on the cycle after CLEAR; this keeps the PE accumulate phase aligned with beats.
- FEED:
  - T = K + 2(N-1) beats, each exactly BEAT cycles, tracked by a cycle counter 0..BEAT-1.
  - beat_idx, skew_mask, a_addr and b_addr change only on the first cycle of a beat and are held stable for the whole beat.
  - beat_strobe is high on that first cycle only.
  - skew_mask[i] = (t >= i) && (t - i < K).
  - Field i of a_addr/b_addr = t - i when the mask bit is set, else 0.
  - The wrapper drives 0.0 on masked-off edges.
  - Address arithmetic is done in KW+1 bits before truncation; no wrap occurs because t - i < K <= 2^KW-1.
  - Beats K+N-1 .. T-1 have skew_mask=0; these are propagation-only beats.
- DRAIN:
  - Lasts DRAIN cycles; all masks and addresses are 0.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
- start in any state other than IDLE is ignored, with no queuing.
- k_len changes after capture have no effect.
- rst asserted mid-operation aborts immediately to the reset values. pe_clr_n=0 during reset clears the PEs.
- A start arriving in the same cycle as DONE is ignored; a start on the next cycle (IDLE) is accepted.

Test Plan:
- Reset then idle:
  - Stimulus: rst low 3 cycles, release, no start.
  - Response: all outputs 0 during reset; pe_clr_n=1 from the first post-reset clock; busy stays 0.
- Basic sequence (N=4, BEAT=6, CLR_CYC=2, DRAIN=12, k_len=3), start at cycle 0:
  - pe_clr_n=0 at cycles 1-2.
  - FEED covers cycles 3-56 (T=9 beats); beat_strobe at 3, 9, 15, ...
  - DRAIN covers cycles 57-68; done=1 at cycle 69; busy high cycles 1-68.
- Skew mask check (same run):
  - skew_mask per beat 0..8 = 0001, 0011, 0111, 1110, 1100, 1000, 0000, 0000, 0000.
  - At beat 3: a_addr fields = {row3:0, row2:1, row1:2, row0:0}.
- k_len=0:
  - start -> two CLEAR cycles, then done on the following cycle.
  - beat_strobe never asserts; busy high for 2 cycles.
- start ignored while busy:
  - Stimulus: k_len=3 run, with start pulses at cycles 10 and 69.
  - Response: no effect on that run; a start at cycle 70 is accepted and a second run begins.
- Abort:
  - Stimulus: rst low at cycle 20 of a k_len=5 run.
  - Response: outputs go to reset values asynchronously; after release, a new start with k_len=2 completes with done at cycle 1+2+(2+6)*6+12 = 63 relative to start.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Beat sequencer for an N x N systolic MAC array: clears the PE accumulators, then walks
// K + 2(N-1) skewed operand beats, waits out the pipeline drain and pulses done.
module systolic_seq_ctrl #(
    parameter int N       = 4,
    parameter int KW      = 8,
    parameter int BEAT    = 6,
    parameter int CLR_CYC = 2,
    parameter int DRAIN   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    output logic              busy,
    output logic              done,
    output logic              pe_clr_n,
    output logic              beat_strobe,
    output logic [KW:0]       beat_idx,
    output logic [N-1:0]      skew_mask,
    output logic [N*KW-1:0]   a_addr,
    output logic [N*KW-1:0]   b_addr
);

    localparam int CMAX = (BEAT > CLR_CYC) ? ((BEAT > DRAIN) ? BEAT : DRAIN)
                                           : ((CLR_CYC > DRAIN) ? CLR_CYC : DRAIN);
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = KW + 1;
    localparam int TW   = KW + 2;

    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] BEAT_LAST  = CW'(BEAT - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);
    localparam logic [TW-1:0] PROP_BEATS = TW'(2 * (N - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clr_n_q, clr_n_d;
    logic                strobe_q, strobe_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [N-1:0]        mask_q, mask_d;
    logic [N*KW-1:0]     a_q, a_d;
    logic [N*KW-1:0]     b_q, b_d;

    logic [BW-1:0]       nxt_t;
    logic [N-1:0]        nxt_mask;
    logic [N*KW-1:0]     nxt_addr;
    logic                last_beat;

    // Row/column i sees operand k = t - i once the wavefront reaches it, for K beats.
    function automatic logic [N-1:0] live_mask(input logic [BW-1:0] t, input logic [KW-1:0] k);
        logic [BW-1:0] iv;
        live_mask = '0;
        for (int i = 0; i < N; i++) begin
            iv = BW'(i);
            live_mask[i] = (t >= iv) && ((t - iv) < {1'b0, k});
        end
    endfunction

    function automatic logic [N*KW-1:0] edge_addr(input logic [BW-1:0] t, input logic [N-1:0] m);
        logic [BW-1:0] d;
        edge_addr = '0;
        for (int i = 0; i < N; i++) begin
            d = t - BW'(i);
            if (m[i]) begin
                edge_addr[i*KW +: KW] = d[KW-1:0];
            end
        end
    endfunction

    assign nxt_t     = (state_q == S_FEED) ? beat_q + BW'(1) : '0;
    assign nxt_mask  = live_mask(nxt_t, k_q);
    assign nxt_addr  = edge_addr(nxt_t, nxt_mask);
    assign last_beat = ({1'b0, beat_q} + TW'(1)) == (TW'(k_q) + PROP_BEATS);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        clr_n_d  = clr_n_q;
        strobe_d = 1'b0;
        beat_d   = beat_q;
        mask_d   = mask_q;
        a_d      = a_q;
        b_d      = b_q;
        case (state_q)
            S_IDLE: begin
                clr_n_d = 1'b1;
                busy_d  = 1'b0;
                if (start) begin
                    k_d     = k_len;
                    cnt_d   = '0;
                    clr_n_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    clr_n_d = 1'b1;
                    if (k_q == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        strobe_d = 1'b1;
                        beat_d   = nxt_t;
                        mask_d   = nxt_mask;
                        a_d      = nxt_addr;
                        b_d      = nxt_addr;
                        state_d  = S_FEED;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FEED: begin
                if (cnt_q == BEAT_LAST) begin
                    cnt_d = '0;
                    if (last_beat) begin
                        beat_d  = '0;
                        mask_d  = '0;
                        a_d     = '0;
                        b_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        strobe_d = 1'b1;
                        beat_d   = nxt_t;
                        mask_d   = nxt_mask;
                        a_d      = nxt_addr;
                        b_d      = nxt_addr;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clr_n_q  <= 1'b0;
            strobe_q <= 1'b0;
            beat_q   <= '0;
            mask_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            clr_n_q  <= clr_n_d;
            strobe_q <= strobe_d;
            beat_q   <= beat_d;
            mask_q   <= mask_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pe_clr_n    = clr_n_q;
    assign beat_strobe = strobe_q;
    assign beat_idx    = beat_q;
    assign skew_mask   = mask_q;
    assign a_addr      = a_q;
    assign b_addr      = b_q;

endmodule
